axi_dma_wr: RTL

AXI_DMA_WR -- requirements
Module: axi_dma_wr

---
 rtl/axi_dma_pkg.sv | 23 ++
 rtl/axi_dma_wr_fifo.sv | 61 ++++++
 rtl/axi_dma_wr.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_pkg.sv
// axi_dma_pkg -- shared definitions for the AXI write DMA.
//   wr_state_e       : write FSM state encoding
//   FIXED_BURST_SIZE : largest burst issued (beats)
//   SIZE_4B / BURST_INCR / RESP_OKAY / QOS_MAX : AXI field constants
package axi_dma_pkg;

    typedef enum logic [2:0] {
        WR_IDLE = 3'd0,
        WR_PRE  = 3'd1,
        WR_ADDR = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4,
        WR_DONE = 3'd5
    } wr_state_e;

    localparam int unsigned FIXED_BURST_SIZE = 256;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] QOS_MAX    = 4'b1111;

endpackage

// File: rtl/axi_dma_wr_fifo.sv
// axi_dma_wr_fifo -- synchronous show-ahead FIFO buffering DMA write data.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data     : push request and data
//   rd_en              : pop request (rd_data is the current head)
//   rd_data            : head word, valid whenever !empty
//   full, empty        : occupancy flags
module axi_dma_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign push_ok = wr_en && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axi_dma_wr.sv
// axi_dma_wr -- streams buffered words to memory as AXI INCR write bursts.
// Optional feature: define DMA_WR_ERR_CHECK_EN to make err_o a sticky flag for
// non-OKAY write responses; otherwise err_o is tied low and BRESP is ignored.
// Ports:
//   clk, rstn                    : clock, asynchronous active-low reset
//   start_dma, num_trans,
//   start_addr                   : transfer request (pulse) with word count / byte address
//   data_i, data_vld_i, data_rdy_o : write-data stream into the internal buffer
//   done_o, err_o                : completion pulse, sticky response error
//   M_AW* / M_W* / M_B*          : AXI write address, data and response channels
module axi_dma_wr
    import axi_dma_pkg::*;
#(
    parameter int BITS_TRANS   = 18,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_ID = 4,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_dma,
    input  logic [BITS_TRANS-1:0]     num_trans,
    input  logic [AXI_WIDTH_AD-1:0]   start_addr,
    input  logic [AXI_WIDTH_DA-1:0]   data_i,
    input  logic                      data_vld_i,
    output logic                      data_rdy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,
    output logic [AXI_WIDTH_AD-1:0]   M_AWADDR,
    output logic [AXI_WIDTH_ID-1:0]   M_AWID,
    output logic [7:0]                M_AWLEN,
    output logic [2:0]                M_AWSIZE,
    output logic [1:0]                M_AWBURST,
    output logic                      M_AWLOCK,
    output logic [3:0]                M_AWCACHE,
    output logic [2:0]                M_AWPROT,
    output logic [3:0]                M_AWQOS,
    output logic [3:0]                M_AWREGION,
    output logic                      M_AWUSER,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,
    output logic [AXI_WIDTH_DA-1:0]   M_WDATA,
    output logic [AXI_WIDTH_DA/8-1:0] M_WSTRB,
    output logic                      M_WLAST,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,
    input  logic [1:0]                M_BRESP,
    input  logic [AXI_WIDTH_ID-1:0]   M_BID
);

    wr_state_e               state_q, state_d;
    logic [BITS_TRANS-1:0]   num_q, num_d;
    logic [BITS_TRANS-1:0]   sent_q, sent_d;
    logic [AXI_WIDTH_AD-1:0] addr_q, addr_d;
    logic [8:0]              beats_q, beats_d;
    logic [7:0]              beat_q, beat_d;
    logic                    ready_q;

    logic                    fifo_full, fifo_empty;
    logic                    aw_hs, w_hs, b_hs;
    logic [BITS_TRANS-1:0]   remaining;
    logic [BITS_TRANS:0]     sent_sum;
    logic [AXI_WIDTH_AD:0]   addr_sum;

    // Constant AXI fields
    assign M_AWID     = '0;
    assign M_AWSIZE   = SIZE_4B;
    assign M_AWBURST  = BURST_INCR;
    assign M_AWLOCK   = 1'b0;
    assign M_AWCACHE  = 4'b0000;
    assign M_AWPROT   = 3'b000;
    assign M_AWQOS    = QOS_MAX;
    assign M_AWREGION = 4'b0000;
    assign M_AWUSER   = 1'b0;
    assign M_WSTRB    = '1;

    assign M_AWADDR = addr_q;
    assign M_AWLEN  = 8'(beats_q - 9'd1);
    assign M_WLAST  = (state_q == WR_DATA) && (beat_q == M_AWLEN);

    // ready_q keeps data_rdy_o low while reset is held, even though the
    // FIFO reports not-full at that time.
    assign data_rdy_o = ready_q && !fifo_full;

    assign aw_hs = M_AWVALID && M_AWREADY;
    assign w_hs  = M_WVALID && M_WREADY;
    assign b_hs  = M_BVALID && M_BREADY;

    axi_dma_wr_fifo #(
        .WIDTH (AXI_WIDTH_DA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (data_vld_i && data_rdy_o),
        .wr_data (data_i),
        .rd_en   (w_hs),
        .rd_data (M_WDATA),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= WR_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE: if (start_dma) state_d = WR_PRE;
            WR_PRE:  state_d = (sent_q == num_q) ? WR_DONE : WR_ADDR;
            WR_ADDR: if (aw_hs) state_d = WR_DATA;
            WR_DATA: if (w_hs && M_WLAST) state_d = WR_RESP;
            WR_RESP: if (b_hs) state_d = WR_PRE;
            WR_DONE: state_d = WR_IDLE;
            default: state_d = WR_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        M_AWVALID = 1'b0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            WR_ADDR: M_AWVALID = 1'b1;
            WR_DATA: M_WVALID  = !fifo_empty;
            WR_RESP: M_BREADY  = 1'b1;
            WR_DONE: done_o    = 1'b1;
            default: ;
        endcase
    end

    // ---------------- transfer bookkeeping ----------------
    always_comb begin
        num_d     = num_q;
        sent_d    = sent_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        beat_d    = beat_q;
        remaining = num_q - sent_q;
        sent_sum  = {1'b0, sent_q} + (BITS_TRANS+1)'(beats_q);
        addr_sum  = {1'b0, addr_q} + (AXI_WIDTH_AD+1)'({beats_q, 2'b00});
        case (state_q)
            WR_IDLE: if (start_dma) begin
                num_d  = num_trans;
                sent_d = '0;
                addr_d = start_addr;
            end
            // Burst length is fixed here so AWLEN stays stable through WR_ADDR.
            WR_PRE: beats_d = (remaining >= BITS_TRANS'(FIXED_BURST_SIZE)) ?
                              9'(FIXED_BURST_SIZE) : 9'(remaining);
            WR_ADDR: beat_d = '0;
            WR_DATA: if (w_hs) beat_d = beat_q + 8'd1;
            // Saturating advance: the counters pin at all-ones instead of wrapping.
            WR_RESP: if (b_hs) begin
                sent_d = sent_sum[BITS_TRANS]   ? '1 : sent_sum[BITS_TRANS-1:0];
                addr_d = addr_sum[AXI_WIDTH_AD] ? '1 : addr_sum[AXI_WIDTH_AD-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_q   <= '0;
            sent_q  <= '0;
            addr_q  <= '0;
            beats_q <= 9'd1;
            beat_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            sent_q  <= sent_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            beat_q  <= beat_d;
            ready_q <= 1'b1;
        end
    end

    // Response IDs are never checked: only one burst is outstanding at a time.
    logic unused_bid;
    assign unused_bid = ^M_BID;

`ifdef DMA_WR_ERR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == WR_IDLE && start_dma) err_d = 1'b0;
        if (b_hs && (M_BRESP != RESP_OKAY))  err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^M_BRESP;
    assign err_o        = 1'b0;
`endif

endmodule
